// File: rtl/alu_pkg.sv
// Shared types, flag bit positions and helpers for the sequential Z80 ALU.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD = 5'd0,
    OP_SUB = 5'd1,
    OP_AND = 5'd2,
    OP_OR  = 5'd3,
    OP_XOR = 5'd4,
    OP_INC = 5'd5,
    OP_SLL = 5'd6,
    OP_SRL = 5'd7,
    OP_SLA = 5'd8,
    OP_SRA = 5'd9,
    OP_ROL = 5'd10,
    OP_ADC = 5'd11,
    OP_SBC = 5'd12,
    OP_CP  = 5'd13,
    OP_SET = 5'd14,
    OP_RES = 5'd15,
    OP_BIT = 5'd16
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } alu_state_e;

  localparam int unsigned FLAG_C  = 0;
  localparam int unsigned FLAG_N  = 1;
  localparam int unsigned FLAG_PV = 2;
  localparam int unsigned FLAG_H  = 4;
  localparam int unsigned FLAG_Z  = 6;
  localparam int unsigned FLAG_S  = 7;

  localparam int unsigned MAX_W = 32;

  // Even parity: 1 when the number of set bits is even (zero-extension is neutral).
  function automatic logic parity(input logic [MAX_W-1:0] v);
    return ~(^v);
  endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational Z80-format flag byte {S,Z,0,H,0,PV,N,C} from a raw WIDTH+1 result.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   raw,
  input  logic             sh_bit,
  input  logic             prev_c,
  output logic [7:0]       flags_c
);

  localparam int unsigned M = WIDTH - 1;

  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] idx;
  logic [WIDTH-1:0] mask;
  logic             half;

  always_comb begin
    res   = raw[WIDTH-1:0];
    b_eff = (op == OP_INC) ? WIDTH'(1) : b;
    idx   = WIDTH'(32'(b) % WIDTH);
    mask  = WIDTH'(1) << idx;
    half  = a[4] ^ b_eff[4] ^ res[4];

    flags_c          = '0;
    flags_c[FLAG_S]  = res[M];
    flags_c[FLAG_Z]  = (res == '0);
    flags_c[FLAG_PV] = parity(32'(res));

    case (op)
      OP_ADD, OP_ADC, OP_INC: begin
        flags_c[FLAG_H]  = half;
        flags_c[FLAG_PV] = (a[M] == b_eff[M]) && (res[M] != a[M]);
        flags_c[FLAG_C]  = (op == OP_INC) ? prev_c : raw[WIDTH];
      end
      OP_SUB, OP_SBC, OP_CP: begin
        flags_c[FLAG_H]  = half;
        flags_c[FLAG_PV] = (a[M] != b[M]) && (res[M] != a[M]);
        flags_c[FLAG_N]  = 1'b1;
        flags_c[FLAG_C]  = raw[WIDTH];
      end
      OP_AND: flags_c[FLAG_H] = 1'b1;
      OP_OR, OP_XOR: ;
      OP_SLL, OP_SLA, OP_SRL, OP_SRA, OP_ROL: flags_c[FLAG_C] = sh_bit;
      OP_SET, OP_RES: flags_c[FLAG_C] = prev_c;
      OP_BIT: begin
        flags_c[FLAG_Z] = ~|(a & mask);
        flags_c[FLAG_C] = prev_c;
      end
      default: flags_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Registered Z80 ALU with valid/ready handshakes; shifts and rotates iterate one bit per cycle.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       opcode,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [7:0]       flags
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  if (WIDTH < 8 || WIDTH > 32) begin : g_width_chk
    $error("alu_seq: WIDTH must be in 8..32");
  end

  alu_state_e       state_q, state_d;
  alu_op_e          op_q, op_d, op_in, fg_op;
  logic [WIDTH-1:0] acc_q, acc_d, out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, k_in;
  logic [7:0]       flags_q, flags_d, fg_flags;
  logic [WIDTH-1:0] idx, mask, res_in, acc_step, fg_a, fg_b;
  logic [WIDTH:0]   raw_in, fg_raw;
  logic [31:0]      b32;
  logic             sh_step, fg_sh, accept;

  // Single-cycle datapath and iteration count, evaluated on the live inputs at accept.
  always_comb begin
    op_in  = alu_op_e'(opcode);
    b32    = 32'(b);
    idx    = WIDTH'(b32 % WIDTH);
    mask   = WIDTH'(1) << idx;
    raw_in = '0;
    k_in   = '0;
    case (op_in)
      OP_ADD: raw_in = {1'b0, a} + {1'b0, b};
      OP_ADC: raw_in = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
      OP_SUB, OP_CP: raw_in = {1'b0, a} - {1'b0, b};
      OP_SBC: raw_in = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, carry_in};
      OP_INC: raw_in = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
      OP_AND: raw_in = {1'b0, a & b};
      OP_OR:  raw_in = {1'b0, a | b};
      OP_XOR: raw_in = {1'b0, a ^ b};
      OP_SET: raw_in = {1'b0, a | mask};
      OP_RES: raw_in = {1'b0, a & ~mask};
      OP_BIT: raw_in = {1'b0, a};
      OP_SLL, OP_SLA, OP_SRL, OP_SRA: begin
        raw_in = {1'b0, a};
        k_in   = (b32 >= WIDTH) ? CNT_W'(WIDTH) : CNT_W'(b32);
      end
      OP_ROL: begin
        raw_in = {1'b0, a};
        k_in   = CNT_W'(b32 % WIDTH);
      end
      default: raw_in = '0;
    endcase
    res_in = (op_in == OP_CP) ? a : raw_in[WIDTH-1:0];
  end

  // One iteration step of the latched shift/rotate.
  always_comb begin
    acc_step = acc_q;
    sh_step  = 1'b0;
    case (op_q)
      OP_SLL, OP_SLA: begin
        acc_step = {acc_q[WIDTH-2:0], 1'b0};
        sh_step  = acc_q[WIDTH-1];
      end
      OP_SRL: begin
        acc_step = {1'b0, acc_q[WIDTH-1:1]};
        sh_step  = acc_q[0];
      end
      OP_SRA: begin
        acc_step = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
        sh_step  = acc_q[0];
      end
      OP_ROL: begin
        acc_step = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]};
        sh_step  = acc_q[WIDTH-1];
      end
      default: ;
    endcase
  end

  // Flags are generated either for the final shift step or for the op being accepted.
  always_comb begin
    fg_op  = op_in;
    fg_a   = a;
    fg_b   = b;
    fg_raw = raw_in;
    fg_sh  = 1'b0;
    if (state_q == S_SHIFT) begin
      fg_op  = op_q;
      fg_a   = acc_step;
      fg_b   = '0;
      fg_raw = {1'b0, acc_step};
      fg_sh  = sh_step;
    end
  end

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .op      (fg_op),
    .a       (fg_a),
    .b       (fg_b),
    .raw     (fg_raw),
    .sh_bit  (fg_sh),
    .prev_c  (flags_q[FLAG_C]),
    .flags_c (fg_flags)
  );

  // Next-state logic; an accept in DONE overrides the return to IDLE.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    flags_d  = flags_q;
    in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    accept   = in_valid && in_ready;

    case (state_q)
      S_SHIFT: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          out_d   = acc_step;
          flags_d = fg_flags;
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: ;
    endcase

    if (accept) begin
      op_d  = op_in;
      acc_d = a;
      cnt_d = k_in;
      if (k_in != '0) begin
        state_d = S_SHIFT;
      end else begin
        state_d = S_DONE;
        out_d   = res_in;
        flags_d = fg_flags;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      flags_q <= flags_d;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign out       = out_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8 and WIDTH=16.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, carry_in;
  logic [7:0]  a, b, out, flags;
  logic [4:0]  opcode;
  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, b16, out16;
  logic [7:0]  flags16;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .carry_in(carry_in),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .flags(flags)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .opcode(5'd0), .carry_in(1'b0),
    .out_valid(out_valid16), .out_ready(out_ready16), .out(out16), .flags(flags16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op with out_ready high, wait for the result, check latency/out/flags.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [7:0] av,
                        input logic [7:0] bv, input logic ci, input logic [7:0] exp_out,
                        input logic [7:0] exp_flags, input logic [7:0] fmask, input int exp_lat);
    int cyc;
    @(negedge clk);
    check({tag, "/in_ready"}, 32'(in_ready), 32'd1);
    opcode = op; a = av; b = bv; carry_in = ci; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'hA5; b = 8'h5A; opcode = 5'd4; carry_in = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "/latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "/out"}, 32'(out), 32'(exp_out));
    check({tag, "/flags"}, 32'(flags & fmask), 32'(exp_flags & fmask));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; opcode = '0; carry_in = 1'b0;
    in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    check("reset/out_valid", 32'(out_valid), 32'd0);
    check("reset/out", 32'(out), 32'd0);
    check("reset/flags", 32'(flags), 32'd0);
    check("reset/in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    //          tag      op     a      b      ci    out    flags  mask   lat
    run_op("add",  5'd0,  8'h7F, 8'h01, 1'b0, 8'h80, 8'h94, 8'hFF, 1);
    run_op("adc",  5'd11, 8'hFF, 8'h00, 1'b1, 8'h00, 8'h51, 8'hFF, 1);
    run_op("inc",  5'd5,  8'h0F, 8'h00, 1'b0, 8'h10, 8'h11, 8'hFF, 1);
    run_op("sbc",  5'd12, 8'h00, 8'h00, 1'b1, 8'hFF, 8'h93, 8'hFF, 1);
    run_op("cp",   5'd13, 8'h10, 8'h20, 1'b0, 8'h10, 8'h83, 8'hFF, 1);
    run_op("and",  5'd2,  8'hF0, 8'h3C, 1'b0, 8'h30, 8'h14, 8'hFF, 1);
    run_op("xor",  5'd4,  8'h55, 8'h55, 1'b0, 8'h00, 8'h44, 8'hFF, 1);
    run_op("sra",  5'd9,  8'hCA, 8'h03, 1'b0, 8'hF9, 8'h84, 8'hFF, 4);
    run_op("sll9", 5'd6,  8'h0F, 8'h09, 1'b0, 8'h00, 8'h40, 8'h40, 9);
    run_op("rol",  5'd10, 8'h80, 8'h0A, 1'b0, 8'h02, 8'h00, 8'hFF, 3);
    run_op("set",  5'd14, 8'h00, 8'h07, 1'b0, 8'h80, 8'h80, 8'hFF, 1);
    run_op("bit",  5'd16, 8'h07, 8'h03, 1'b0, 8'h07, 8'h40, 8'hFF, 1);
    run_op("undef",5'd20, 8'hFF, 8'h01, 1'b1, 8'h00, 8'h00, 8'hFF, 1);
    run_op("res",  5'd15, 8'hFF, 8'h09, 1'b0, 8'hFD, 8'h80, 8'hFF, 1);
    run_op("srl0", 5'd7,  8'h81, 8'h00, 1'b0, 8'h81, 8'h84, 8'hFF, 1);

    // Backpressure: result must hold while out_ready is low.
    @(negedge clk);
    opcode = 5'd0; a = 8'h01; b = 8'h02; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("hold/out_valid", 32'(out_valid), 32'd1);
      check("hold/in_ready", 32'(in_ready), 32'd0);
      check("hold/out", 32'(out), 32'h03);
      check("hold/flags", 32'(flags), 32'h00);
      @(negedge clk);
    end
    opcode = 5'd0; a = 8'h10; b = 8'h20; in_valid = 1'b1; out_ready = 1'b1;
    #1 check("reload/in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("reload/out_valid", 32'(out_valid), 32'd1);
    check("reload/out", 32'(out), 32'h30);
    for (int i = 0; i < 4; i++) begin
      a = 8'(8'h11 * i); b = 8'h70;
      @(posedge clk);
      @(negedge clk);
      check("b2b/out_valid", 32'(out_valid), 32'd1);
      check("b2b/out", 32'(out), 32'(8'(8'h11 * i + 8'h70)));
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b/idle", 32'(out_valid), 32'd0);

    // Reset in the middle of an SRA abandons it.
    opcode = 5'd9; a = 8'h80; b = 8'h06; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst/out_valid", 32'(out_valid), 32'd0);
    check("midrst/out", 32'(out), 32'd0);
    check("midrst/flags", 32'(flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst/no_result", 32'(out_valid), 32'd0);
    run_op("add_after_rst", 5'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 8'h94, 8'hFF, 1);

    // WIDTH=16 overflow case.
    @(negedge clk);
    a16 = 16'h7FFF; b16 = 16'h0001; in_valid16 = 1'b1; out_ready16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid16 = 1'b0;
    check("w16/out_valid", 32'(out_valid16), 32'd1);
    check("w16/out", 32'(out16), 32'h8000);
    check("w16/flags", 32'(flags16), 32'h94);
    check("w16/pv", 32'(flags16[2]), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
